// File: rtl/sdes_fk_pipe.sv
// Two-stage pipelined S-DES round function fk with valid/ready on both sides.
// Optional macro SDES_FK_SWAP_EN adds a per-word swap input that applies SW after fk.

module sdes_s1 (
    input  logic [3:0] q_in,
    output logic [1:0] q_out
);

    // S1 lookup indexed by {row, col} = {q_in[3], q_in[0], q_in[2], q_in[1]}
    always_comb begin
        q_out = 2'd0;
        case ({q_in[3], q_in[0], q_in[2], q_in[1]})
            4'd0:    q_out = 2'd0;
            4'd1:    q_out = 2'd1;
            4'd2:    q_out = 2'd2;
            4'd3:    q_out = 2'd3;
            4'd4:    q_out = 2'd2;
            4'd5:    q_out = 2'd0;
            4'd6:    q_out = 2'd1;
            4'd7:    q_out = 2'd3;
            4'd8:    q_out = 2'd3;
            4'd9:    q_out = 2'd0;
            4'd10:   q_out = 2'd1;
            4'd11:   q_out = 2'd0;
            4'd12:   q_out = 2'd2;
            4'd13:   q_out = 2'd1;
            4'd14:   q_out = 2'd0;
            4'd15:   q_out = 2'd3;
            default: q_out = 2'd0;
        endcase
    end

endmodule

module sdes_fk_pipe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] din,
    input  logic [7:0] key,
`ifdef SDES_FK_SWAP_EN
    input  logic       swap,
`endif
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] dout
);

    function automatic logic [1:0] s0_lookup(input logic [3:0] idx);
        logic [1:0] v;
        v = 2'd0;
        case (idx)
            4'd0:    v = 2'd1;
            4'd1:    v = 2'd0;
            4'd2:    v = 2'd3;
            4'd3:    v = 2'd2;
            4'd4:    v = 2'd3;
            4'd5:    v = 2'd2;
            4'd6:    v = 2'd1;
            4'd7:    v = 2'd0;
            4'd8:    v = 2'd0;
            4'd9:    v = 2'd2;
            4'd10:   v = 2'd1;
            4'd11:   v = 2'd3;
            4'd12:   v = 2'd3;
            4'd13:   v = 2'd1;
            4'd14:   v = 2'd3;
            4'd15:   v = 2'd2;
            default: v = 2'd0;
        endcase
        return v;
    endfunction

    logic       a_valid_q, a_valid_d;
    logic [3:0] a_l_q, a_l_d;
    logic [3:0] a_r_q, a_r_d;
    logic [7:0] a_x_q, a_x_d;
    logic       a_swap_q, a_swap_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] dout_q, dout_d;

    logic       out_free_s;
    logic       accept_s;
    logic       swap_s;
    logic [7:0] ep_s;
    logic [1:0] s0_s;
    logic [1:0] s1_s;
    logic [3:0] sbox_s;
    logic [3:0] p4_s;
    logic [7:0] fk_s;

`ifdef SDES_FK_SWAP_EN
    assign swap_s = swap;
`else
    assign swap_s = 1'b0;
`endif

    sdes_s1 u_s1 (
        .q_in  (a_x_q[3:0]),
        .q_out (s1_s)
    );

    // Handshake, expansion/key mix ahead of stage A, and round result from stage A
    always_comb begin
        out_free_s = !out_valid_q || out_ready;
        in_ready   = !a_valid_q || out_free_s;
        accept_s   = in_valid && in_ready;

        ep_s   = {din[0], din[3], din[2], din[1], din[2], din[1], din[0], din[3]};
        s0_s   = s0_lookup({a_x_q[7], a_x_q[4], a_x_q[6], a_x_q[5]});
        sbox_s = {s0_s, s1_s};
        p4_s   = {sbox_s[2], sbox_s[0], sbox_s[1], sbox_s[3]};
        if (a_swap_q) begin
            fk_s = {a_r_q, a_l_q ^ p4_s};
        end else begin
            fk_s = {a_l_q ^ p4_s, a_r_q};
        end

        a_valid_d = accept_s || (a_valid_q && !out_free_s);
        if (accept_s) begin
            a_l_d    = din[7:4];
            a_r_d    = din[3:0];
            a_x_d    = ep_s ^ key;
            a_swap_d = swap_s;
        end else begin
            a_l_d    = a_l_q;
            a_r_d    = a_r_q;
            a_x_d    = a_x_q;
            a_swap_d = a_swap_q;
        end

        // Output register reloads whenever it is empty or its word is leaving
        if (out_free_s) begin
            out_valid_d = a_valid_q;
            dout_d      = a_valid_q ? fk_s : dout_q;
        end else begin
            out_valid_d = out_valid_q;
            dout_d      = dout_q;
        end
    end

    // Pipeline state; reset discards any in-flight words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid_q   <= 1'b0;
            a_l_q       <= 4'h0;
            a_r_q       <= 4'h0;
            a_x_q       <= 8'h00;
            a_swap_q    <= 1'b0;
            out_valid_q <= 1'b0;
            dout_q      <= 8'h00;
        end else begin
            a_valid_q   <= a_valid_d;
            a_l_q       <= a_l_d;
            a_r_q       <= a_r_d;
            a_x_q       <= a_x_d;
            a_swap_q    <= a_swap_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;

endmodule

// File: tb/tb_sdes_fk_pipe.sv
// Directed and scoreboard-checked bench for sdes_fk_pipe (works with or without SDES_FK_SWAP_EN).

module tb_sdes_fk_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] din;
    logic [7:0] key;
    logic       swap_i;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] dout;

    int n_cmp;
    int n_bad;
    logic [7:0] exp_q[$];
    logic acc;
    logic cmp;

`ifdef SDES_FK_SWAP_EN
    localparam bit SWAP_EN = 1'b1;
`else
    localparam bit SWAP_EN = 1'b0;
`endif

    sdes_fk_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .key       (key),
`ifdef SDES_FK_SWAP_EN
        .swap      (swap_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference S-boxes as flat row-major tables (row*4+col)
    function automatic logic [1:0] s0_tab(input int r, input int c);
        int t[16] = '{1,0,3,2, 3,2,1,0, 0,2,1,3, 3,1,3,2};
        return 2'(t[r*4+c]);
    endfunction

    function automatic logic [1:0] s1_tab(input int r, input int c);
        int t[16] = '{0,1,2,3, 2,0,1,3, 3,0,1,0, 2,1,0,3};
        return 2'(t[r*4+c]);
    endfunction

    function automatic logic [7:0] fk_ref(input logic [7:0] d, input logic [7:0] k, input logic sw);
        logic [3:0] l, r, p;
        logic [7:0] x;
        logic [1:0] a, b;
        l = d[7:4];
        r = d[3:0];
        x = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]} ^ k;
        a = s0_tab(int'({x[7], x[4]}), int'({x[6], x[5]}));
        b = s1_tab(int'({x[3], x[0]}), int'({x[2], x[1]}));
        p = {a[0], b[0], b[1], a[1]};
        if (sw && SWAP_EN) return {r, l ^ p};
        return {l ^ p, r};
    endfunction

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // One clock: sample handshakes before the rising edge, score completions, move to next negedge
    task automatic cycle_step();
        #1;
        acc = in_valid && in_ready;
        cmp = out_valid && out_ready;
        if (cmp) begin
            if (exp_q.size() == 0) check_val("unexpected_out", 16'(out_valid), 16'd0);
            else check_val("dout", 16'(dout), 16'(exp_q.pop_front()));
        end
        if (acc) exp_q.push_back(fk_ref(din, key, swap_i));
        @(negedge clk);
    endtask

    task automatic run_vec(input logic [7:0] d, input logic [7:0] k, input logic sw, input logic [7:0] expv);
        in_valid = 1'b1; din = d; key = k; swap_i = sw; out_ready = 1'b1;
        cycle_step();
        check_val("vec_accept", 16'(acc), 16'd1);
        in_valid = 1'b0;
        check_val("vec_lat1_valid", 16'(out_valid), 16'd0);
        cycle_step();
        check_val("vec_lat2_valid", 16'(out_valid), 16'd1);
        check_val("vec_dout", 16'(dout), 16'(expv));
        cycle_step();
        swap_i = 1'b0;
    endtask

    initial begin
        logic [7:0] w_d[4];
        logic [7:0] w_k[4];
        logic [7:0] held;
        int idx, ncomp, guard;

        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; in_valid = 1'b0; din = 8'h00; key = 8'h00; swap_i = 1'b0; out_ready = 1'b0;
        acc = 1'b0; cmp = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_out_valid", 16'(out_valid), 16'd0);
        check_val("rst_dout", 16'(dout), 16'h0000);
        check_val("rst_in_ready", 16'(in_ready), 16'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_in_ready", 16'(in_ready), 16'd1);

        run_vec(8'hA5, 8'h00, 1'b0, 8'hB5);
        run_vec(8'h00, 8'h00, 1'b0, 8'h80);
        run_vec(8'h00, 8'hFF, 1'b0, 8'h70);
        if (SWAP_EN) run_vec(8'hA5, 8'h00, 1'b1, 8'h5B);

        // Backpressure: 4 words offered with the sink stalled
        w_d = '{8'h12, 8'h34, 8'h56, 8'h78};
        w_k = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
        idx = 0; held = 8'h00;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (idx < 4);
            din = w_d[idx % 4]; key = w_k[idx % 4];
            cycle_step();
            if (acc) idx++;
            if (c == 2) held = dout;
        end
        check_val("bp_accepts", 16'(idx), 16'd2);
        check_val("bp_in_ready", 16'(in_ready), 16'd0);
        check_val("bp_out_valid", 16'(out_valid), 16'd1);
        check_val("bp_dout_stable", 16'(dout), 16'(held));
        check_val("bp_dout_first", 16'(dout), 16'(fk_ref(w_d[0], w_k[0], 1'b0)));
        out_ready = 1'b1; ncomp = 0; guard = 0;
        while ((idx < 4 || exp_q.size() != 0) && guard < 40) begin
            in_valid = (idx < 4);
            din = w_d[idx % 4]; key = w_k[idx % 4];
            cycle_step();
            if (acc) idx++;
            if (cmp) ncomp++;
            guard++;
        end
        in_valid = 1'b0;
        check_val("bp_completions", 16'(ncomp), 16'd4);
        check_val("bp_drained", 16'(exp_q.size()), 16'd0);

        // Throughput: 16 back-to-back random words, one result per cycle once primed
        ncomp = 0;
        for (int c = 0; c < 18; c++) begin
            in_valid = (c < 16);
            din = 8'($urandom); key = 8'($urandom); swap_i = 1'($urandom);
            cycle_step();
            if (c < 16) check_val("tp_accept", 16'(acc), 16'd1);
            if (cmp) ncomp++;
        end
        in_valid = 1'b0; swap_i = 1'b0;
        cycle_step();
        check_val("tp_results", 16'(ncomp), 16'd16);
        check_val("tp_drained", 16'(exp_q.size()), 16'd0);

        // Sweep: every din against 16 keys with random sink stalls
        guard = 0;
        for (int d = 0; d < 256; d++) begin
            for (int k = 0; k < 16; k++) begin
                in_valid = 1'b1; din = 8'(d); key = 8'(k * 17);
                do begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    cycle_step();
                    guard++;
                end while (!acc && guard < 20000);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) cycle_step();
        check_val("sweep_guard", 16'(guard < 20000), 16'd1);
        check_val("sweep_drained", 16'(exp_q.size()), 16'd0);

        // Reset with two words in flight
        out_ready = 1'b0; in_valid = 1'b1;
        din = 8'h3C; key = 8'h5A; cycle_step();
        din = 8'hC3; key = 8'hA5; cycle_step();
        in_valid = 1'b0;
        check_val("mid_in_flight", 16'(exp_q.size()), 16'd2);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_out_valid", 16'(out_valid), 16'd0);
        check_val("mid_rst_dout", 16'(dout), 16'h0000);
        check_val("mid_rst_in_ready", 16'(in_ready), 16'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle_step();
            check_val("post_rst_no_stale", 16'(out_valid), 16'd0);
        end
        check_val("post_rst_in_ready2", 16'(in_ready), 16'd1);
        run_vec(8'hA5, 8'h00, 1'b0, 8'hB5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
